// File: rtl/data_bridge_fifo_if.sv
// Bundle of the DV-side handshake, DL bus and capture signals for data_bridge_fifo.
// The bridge sits on the slave modport; the DV/bus environment uses master.
interface data_bridge_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH-1:0]               out_data;
    logic [WIDTH-1:0]               DL_out;
    logic                           DL_oe;
    logic [WIDTH-1:0]               DL_in;
    logic                           in_capture;
    logic [WIDTH-1:0]               in_data;
    logic                           in_valid;
    logic [$clog2(DEPTH+1)-1:0]     count;

    modport slave (
        input  out_valid, out_data, DL_in, in_capture,
        output out_ready, DL_out, DL_oe, in_data, in_valid, count
    );

    modport master (
        output out_valid, out_data, DL_in, in_capture,
        input  out_ready, DL_out, DL_oe, in_data, in_valid, count
    );
endinterface

// File: rtl/data_bridge_fifo.sv
// DV->DL bridge with a DEPTH-entry word FIFO. Each queued word is played onto the
// precharged DL bus as PRECH_CYCLES cycles of precharge followed by one DRIVE cycle.
// A separate capture path returns the wired-AND bus value to the DV side.
module data_bridge_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int PRECH_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    data_bridge_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (PRECH_CYCLES > 1) ? $clog2(PRECH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    // Slot sequencer
    state_t           state_reg;
    logic [PW-1:0]    prech_cnt_reg;
    logic [WIDTH-1:0] dl_out_reg;
    logic             dl_oe_reg;

    // Capture path
    logic [WIDTH-1:0] in_data_reg;
    logic             in_valid_reg;

    logic             push;
    logic             pop;

    // Ready depends only on the registered occupancy, so a full FIFO refuses
    // a push even in a cycle that pops.
    assign bus.out_ready = (count_reg < CW'(DEPTH));
    assign push          = bus.out_valid && bus.out_ready;
    assign pop           = (state_reg == DRIVE);

    assign bus.count     = count_reg;
    assign bus.DL_out    = dl_out_reg;
    assign bus.DL_oe     = dl_oe_reg;
    assign bus.in_data   = in_data_reg;
    assign bus.in_valid  = in_valid_reg;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Word storage; written only at the tail, never at an occupied head
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.out_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Slot sequencer with registered bus outputs; the head word is read from
    // storage on the transition into DRIVE, so DL_out is a clean flop output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            prech_cnt_reg <= '0;
            dl_out_reg    <= '1;
            dl_oe_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    dl_out_reg <= '1;
                    dl_oe_reg  <= 1'b0;
                    if (count_reg != '0) begin
                        state_reg     <= PRECH;
                        prech_cnt_reg <= '0;
                    end
                end
                PRECH: begin
                    if (prech_cnt_reg == PW'(PRECH_CYCLES - 1)) begin
                        state_reg  <= DRIVE;
                        dl_out_reg <= mem[rd_ptr_reg];
                        dl_oe_reg  <= 1'b1;
                    end else begin
                        prech_cnt_reg <= prech_cnt_reg + PW'(1);
                        dl_out_reg    <= '1;
                        dl_oe_reg     <= 1'b0;
                    end
                end
                DRIVE: begin
                    // Continue straight into the next slot only if words remain
                    // behind the one being popped now.
                    dl_out_reg <= '1;
                    dl_oe_reg  <= 1'b0;
                    if (count_reg > CW'(1)) begin
                        state_reg     <= PRECH;
                        prech_cnt_reg <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    prech_cnt_reg <= '0;
                    dl_out_reg    <= '1;
                    dl_oe_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Capture of the bus value; dl_out_reg is all-ones outside DRIVE, so the
    // AND yields the wired-AND result while driving and plain DL_in otherwise.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_data_reg  <= '0;
            in_valid_reg <= 1'b0;
        end else begin
            in_valid_reg <= bus.in_capture;
            if (bus.in_capture) begin
                in_data_reg <= bus.DL_in & dl_out_reg;
            end
        end
    end
endmodule

// File: tb/tb_data_bridge_fifo.sv
// Self-checking bench for data_bridge_fifo: directed steps followed by random traffic,
// all checked against a slot-schedule model of the bridge.
module tb_data_bridge_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int P     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_bridge_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    data_bridge_fifo #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .PRECH_CYCLES (P)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_assert   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int last_sched = -1000;

    // Model: queued words with the cycle each one is due on the bus
    logic [7:0] q_data [$];
    int         q_drive [$];
    logic [7:0] m_in_data  = 8'h00;
    logic       m_in_valid = 1'b0;

    logic [7:0] exp_t3 [10];
    logic       saw_full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Check the current cycle against the model, advance the model with the
    // inputs applied this cycle, then move to the next cycle.
    task automatic tick();
        logic [7:0] e_out;
        logic       drv;
        logic       acc;
        int         sched;
        drv   = (q_drive.size() > 0) && (q_drive[0] == cyc);
        e_out = drv ? q_data[0] : 8'hFF;
        check("dl_out",    32'(bus.DL_out),    32'(e_out));
        check("dl_oe",     32'(bus.DL_oe),     32'(drv));
        check("count",     32'(bus.count),     32'(q_data.size()));
        check("out_ready", 32'(bus.out_ready), 32'(q_data.size() < DEPTH));
        check("in_valid",  32'(bus.in_valid),  32'(m_in_valid));
        check("in_data",   32'(bus.in_data),   32'(m_in_data));
        if (drv) $display("cycle %0d: slot drives %02h", cyc, e_out);
        acc = bus.out_valid && (q_data.size() < DEPTH);
        if (rst) begin
            q_data.delete();
            q_drive.delete();
            last_sched = -1000;
            m_in_valid = 1'b0;
            m_in_data  = 8'h00;
        end else begin
            if (drv) begin
                void'(q_data.pop_front());
                void'(q_drive.pop_front());
            end
            if (acc) begin
                sched = cyc + P + 2;
                if (last_sched + P + 1 > sched) sched = last_sched + P + 1;
                q_data.push_back(bus.out_data);
                q_drive.push_back(sched);
                last_sched = sched;
                $display("cycle %0d: push %02h, due on bus at cycle %0d", cyc, bus.out_data, sched);
            end
            m_in_valid = bus.in_capture;
            if (bus.in_capture) begin
                m_in_data = bus.DL_in & e_out;
                $display("cycle %0d: capture DL_in=%02h -> %02h", cyc, bus.DL_in, m_in_data);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bus.out_valid  = 1'b0;
        bus.out_data   = 8'h00;
        bus.DL_in      = 8'h00;
        bus.in_capture = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        // T1: reset held two cycles in the middle of traffic
        bus.in_capture = 1'b1;
        bus.out_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.out_data = 8'($urandom);
            bus.DL_in    = 8'($urandom);
            tick();
        end
        bus.out_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.in_capture = 1'b0;
        check("t1_dl_out",    32'(bus.DL_out),    32'(8'hFF));
        check("t1_dl_oe",     32'(bus.DL_oe),     32'(0));
        check("t1_count",     32'(bus.count),     32'(0));
        check("t1_in_valid",  32'(bus.in_valid),  32'(0));
        check("t1_out_ready", 32'(bus.out_ready), 32'(1));

        // T2: single word timing, then T5 wired-AND capture during its DRIVE
        bus.out_valid = 1'b1;
        bus.out_data  = 8'hA5;
        tick();
        bus.out_valid = 1'b0;
        tick();
        check("t2_prech_out", 32'(bus.DL_out), 32'(8'hFF));
        check("t2_prech_oe",  32'(bus.DL_oe),  32'(0));
        tick();
        check("t2_drive_out", 32'(bus.DL_out), 32'(8'hA5));
        check("t2_drive_oe",  32'(bus.DL_oe),  32'(1));
        bus.DL_in      = 8'h0F;
        bus.in_capture = 1'b1;
        tick();
        check("t2_count_after", 32'(bus.count),    32'(0));
        check("t5_wand_data",   32'(bus.in_data),  32'(8'h05));
        check("t5_wand_valid",  32'(bus.in_valid), 32'(1));
        bus.DL_in = 8'h3C;
        tick();
        check("t5_idle_data",  32'(bus.in_data),  32'(8'h3C));
        check("t5_idle_valid", 32'(bus.in_valid), 32'(1));
        bus.in_capture = 1'b0;
        tick();
        check("t5_valid_drop", 32'(bus.in_valid), 32'(0));
        repeat (2) tick();

        // T3: three consecutive pushes, slots every P+1 cycles with idle bus between
        exp_t3[0] = 8'hFF; exp_t3[1] = 8'hFF; exp_t3[2] = 8'hFF; exp_t3[3] = 8'h01;
        exp_t3[4] = 8'hFF; exp_t3[5] = 8'h02; exp_t3[6] = 8'hFF; exp_t3[7] = 8'h03;
        exp_t3[8] = 8'hFF; exp_t3[9] = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            bus.out_valid = (k < 3);
            bus.out_data  = 8'(k + 1);
            check("t3_slot", 32'(bus.DL_out), 32'(exp_t3[k]));
            tick();
        end

        // T4: continuous offer fills the FIFO; pushes while full are dropped
        saw_full = 1'b0;
        bus.out_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.out_data = 8'($urandom);
            if (32'(bus.count) == 32'(DEPTH)) begin
                check("t4_ready_full", 32'(bus.out_ready), 32'(0));
                saw_full = 1'b1;
            end
            tick();
        end
        bus.out_valid = 1'b0;
        check("t4_saw_full", 32'(saw_full), 32'(1));
        repeat (14) tick();

        // T6: reset during DRIVE with three words queued
        bus.out_valid = 1'b1;
        bus.out_data  = 8'($urandom);
        tick();
        bus.out_data  = 8'($urandom);
        tick();
        bus.out_data  = 8'($urandom);
        tick();
        check("t6_drive_oe", 32'(bus.DL_oe), 32'(1));
        check("t6_queued",   32'(bus.count), 32'(3));
        bus.out_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_count", 32'(bus.count), 32'(0));
        check("t6_rst_oe",    32'(bus.DL_oe), 32'(0));
        repeat (6) tick();

        // T6: push and pop in the same cycle leave count unchanged
        bus.out_valid = 1'b1;
        bus.out_data  = 8'h5A;
        tick();
        bus.out_valid = 1'b0;
        tick();
        tick();
        check("t6_pp_drive", 32'(bus.DL_oe), 32'(1));
        check("t6_pp_before", 32'(bus.count), 32'(1));
        bus.out_valid = 1'b1;
        bus.out_data  = 8'hC3;
        tick();
        bus.out_valid = 1'b0;
        check("t6_pp_after", 32'(bus.count), 32'(1));
        repeat (8) tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.out_valid  = ($urandom_range(0, 2) != 0);
            bus.out_data   = 8'($urandom);
            bus.in_capture = ($urandom_range(0, 3) == 0);
            bus.DL_in      = 8'($urandom);
            tick();
        end
        rst            = 1'b0;
        bus.out_valid  = 1'b0;
        bus.in_capture = 1'b0;
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
